// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU slice.
//   - opcode / funct codes of the supported MIPS instructions
//   - bit positions of the flag vector
//   - decoded operation enum and barrel-shifter mode enum
//   - helper for 16-bit immediate sign extension
package alu_pkg;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Flag vector bit positions
  localparam int unsigned FLAG_OVF  = 0;
  localparam int unsigned FLAG_NEG  = 1;
  localparam int unsigned FLAG_ZERO = 2;

  typedef enum logic [4:0] {
    OP_NONE   = 5'd0,
    OP_ADD    = 5'd1,
    OP_ADDU   = 5'd2,
    OP_SUB    = 5'd3,
    OP_SUBU   = 5'd4,
    OP_AND    = 5'd5,
    OP_OR     = 5'd6,
    OP_XOR    = 5'd7,
    OP_NOR    = 5'd8,
    OP_SLT    = 5'd9,
    OP_SLTU   = 5'd10,
    OP_SHIFT  = 5'd11,
    OP_ADDI   = 5'd12,
    OP_ADDIU  = 5'd13,
    OP_SLTI   = 5'd14,
    OP_SLTIU  = 5'd15,
    OP_MEM    = 5'd16,
    OP_BRANCH = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_mode_e;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational 32-bit barrel shifter.
//   data    in  32  value to shift
//   amount  in  5   shift distance
//   mode    in  2   SH_LL logical left, SH_RL logical right, SH_RA arithmetic right
//   shifted out 32  shifted value (0 for an undefined mode)
module alu_shifter
  import alu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [4:0]  amount,
  input  shift_mode_e mode,
  output logic [31:0] shifted
);

  // Select shift direction / fill
  always_comb begin
    shifted = 32'd0;
    case (mode)
      SH_LL:   shifted = data << amount;
      SH_RL:   shifted = data >> amount;
      SH_RA:   shifted = 32'($signed(data) >>> amount);
      default: shifted = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu: single-cycle MIPS-style ALU with one output register stage.
//   clock        in  1   rising-edge clock
//   reset_n      in  1   asynchronous active-low reset
//   instruction  in  32  opcode[31:26] shamt[10:6] funct[5:0] imm[15:0]
//   regA         in  32  rs operand, source of every shift
//   regB         in  32  rt operand, variable shift amount in [4:0]
//   result       out 32  registered result
//   flags        out 3   registered {zero, negative, overflow}
// Build option: define ALU_VSHIFT_EN to include sllv/srlv/srav; otherwise
// those funct codes decode as unsupported.
module alu
  import alu_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic [31:0] regA,
  input  logic [31:0] regB,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [31:0] imm_s;
  alu_op_e     op_s;
  shift_mode_e sh_mode_s;
  logic [4:0]  sh_amt_s;
  logic [31:0] sh_out_s;
  logic [31:0] add_s, sub_s, addi_s;
  logic        ovf_add_s, ovf_sub_s, ovf_addi_s;
  logic [31:0] res_s;
  logic [2:0]  flg_s;
  logic        unused_s;

  assign opcode_s = instruction[31:26];
  assign funct_s  = instruction[5:0];
  assign imm_s    = sext16(instruction[15:0]);
  // rs/rt register-number fields are not needed by the ALU itself
  assign unused_s = &{1'b0, instruction[25:16]};

  // Decode opcode/funct into an operation and shifter controls
  always_comb begin
    op_s      = OP_NONE;
    sh_mode_s = SH_LL;
    sh_amt_s  = instruction[10:6];
    case (opcode_s)
      OPC_RTYPE: begin
        case (funct_s)
          FN_ADD:  op_s = OP_ADD;
          FN_ADDU: op_s = OP_ADDU;
          FN_SUB:  op_s = OP_SUB;
          FN_SUBU: op_s = OP_SUBU;
          FN_AND:  op_s = OP_AND;
          FN_OR:   op_s = OP_OR;
          FN_XOR:  op_s = OP_XOR;
          FN_NOR:  op_s = OP_NOR;
          FN_SLT:  op_s = OP_SLT;
          FN_SLTU: op_s = OP_SLTU;
          FN_SLL:  begin op_s = OP_SHIFT; sh_mode_s = SH_LL; end
          FN_SRL:  begin op_s = OP_SHIFT; sh_mode_s = SH_RL; end
          FN_SRA:  begin op_s = OP_SHIFT; sh_mode_s = SH_RA; end
`ifdef ALU_VSHIFT_EN
          FN_SLLV: begin op_s = OP_SHIFT; sh_mode_s = SH_LL; sh_amt_s = regB[4:0]; end
          FN_SRLV: begin op_s = OP_SHIFT; sh_mode_s = SH_RL; sh_amt_s = regB[4:0]; end
          FN_SRAV: begin op_s = OP_SHIFT; sh_mode_s = SH_RA; sh_amt_s = regB[4:0]; end
`endif
          default: op_s = OP_NONE;
        endcase
      end
      OPC_ADDI:  op_s = OP_ADDI;
      OPC_ADDIU: op_s = OP_ADDIU;
      OPC_SLTI:  op_s = OP_SLTI;
      OPC_SLTIU: op_s = OP_SLTIU;
      OPC_LW:    op_s = OP_MEM;
      OPC_SW:    op_s = OP_MEM;
      OPC_BEQ:   op_s = OP_BRANCH;
      OPC_BNE:   op_s = OP_BRANCH;
      default:   op_s = OP_NONE;
    endcase
  end

  alu_shifter u_shifter (
    .data    (regA),
    .amount  (sh_amt_s),
    .mode    (sh_mode_s),
    .shifted (sh_out_s)
  );

  assign add_s  = regA + regB;
  assign sub_s  = regA - regB;
  assign addi_s = regA + imm_s;

  // Signed overflow: operands agree in sign (B inverted for sub) but the sum does not
  assign ovf_add_s  = (regA[31] == regB[31])  && (add_s[31]  != regA[31]);
  assign ovf_sub_s  = (regA[31] != regB[31])  && (sub_s[31]  != regA[31]);
  assign ovf_addi_s = (regA[31] == imm_s[31]) && (addi_s[31] != regA[31]);

  // Operation result and flag generation
  always_comb begin
    res_s = 32'd0;
    flg_s = 3'b000;
    case (op_s)
      OP_ADD:    begin res_s = add_s;  flg_s[FLAG_OVF] = ovf_add_s;  end
      OP_ADDU:   res_s = add_s;
      OP_SUB:    begin res_s = sub_s;  flg_s[FLAG_OVF] = ovf_sub_s;  end
      OP_SUBU:   res_s = sub_s;
      OP_AND:    res_s = regA & regB;
      OP_OR:     res_s = regA | regB;
      OP_XOR:    res_s = regA ^ regB;
      OP_NOR:    res_s = ~(regA | regB);
      OP_SLT:    res_s = {31'd0, $signed(regA) < $signed(regB)};
      OP_SLTU:   res_s = {31'd0, regA < regB};
      OP_SHIFT:  res_s = sh_out_s;
      OP_ADDI:   begin res_s = addi_s; flg_s[FLAG_OVF] = ovf_addi_s; end
      OP_ADDIU:  res_s = addi_s;
      OP_SLTI:   res_s = {31'd0, $signed(regA) < $signed(imm_s)};
      OP_SLTIU:  res_s = {31'd0, regA < imm_s};
      OP_MEM:    res_s = addi_s;
      OP_BRANCH: begin res_s = sub_s; flg_s[FLAG_ZERO] = (regA == regB); end
      default:   begin res_s = 32'd0; flg_s = 3'b000; end
    endcase
    // Compare-class ops report their outcome on the negative flag
    if (op_s == OP_SLT || op_s == OP_SLTU || op_s == OP_SLTI || op_s == OP_SLTIU) begin
      flg_s[FLAG_NEG] = res_s[0];
    end else begin
      flg_s[FLAG_NEG] = 1'b0;
    end
  end

  // Output register stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result <= 32'd0;
      flags  <= 3'b000;
    end else begin
      result <= res_s;
      flags  <= flg_s;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu. Directed vector table, reset
// sequences, then randomized operations against a plain-arithmetic model.
module tb_alu;

  logic        clock;
  logic        reset_n;
  logic [31:0] instruction;
  logic [31:0] regA;
  logic [31:0] regB;
  logic [31:0] result;
  logic [2:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  localparam longint S32_MAX = 64'sd2147483647;
  localparam longint S32_MIN = -64'sd2147483648;

  alu dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instruction (instruction),
    .regA        (regA),
    .regB        (regB),
    .result      (result),
    .flags       (flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 5'd0, 5'd0, 5'd0, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [15:0] imm);
    return {opc, 5'd0, 5'd0, imm};
  endfunction

  function automatic void add_vec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] res, input logic [2:0] flg);
    vec_t v;
    v.ins = ins; v.a = a; v.b = b; v.res = res; v.flg = flg;
    vecs.push_back(v);
  endfunction

  // Reference model: MIPS semantics expressed with 64-bit integer arithmetic
  function automatic void model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [2:0] f);
    longint sa, sb, si, s;
    longint unsigned ua, ub, ui, t;
    int sh;
    logic [31:0] imm;
    logic [5:0] fn;
    imm = {{16{ins[15]}}, ins[15:0]};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    si = longint'($signed(imm));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ui = {32'd0, imm};
    fn = ins[5:0];
    r = 32'd0;
    f = 3'b000;
    sh = (fn == 6'h04 || fn == 6'h06 || fn == 6'h07) ? int'(b[4:0]) : int'(ins[10:6]);
    case (ins[31:26])
      6'h00: begin
        case (fn)
          6'h20: begin s = sa + sb; r = s[31:0]; f[0] = (s > S32_MAX) || (s < S32_MIN); end
          6'h21: begin t = ua + ub; r = t[31:0]; end
          6'h22: begin s = sa - sb; r = s[31:0]; f[0] = (s > S32_MAX) || (s < S32_MIN); end
          6'h23: begin s = sa - sb; r = s[31:0]; end
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h26: r = a ^ b;
          6'h27: r = ~(a | b);
          6'h2A: begin r = (sa < sb) ? 32'd1 : 32'd0; f[1] = r[0]; end
          6'h2B: begin r = (ua < ub) ? 32'd1 : 32'd0; f[1] = r[0]; end
          6'h00: begin t = ua * (64'd1 << sh); r = t[31:0]; end
          6'h02: begin t = ua / (64'd1 << sh); r = t[31:0]; end
          6'h03: begin s = sa >>> sh; r = s[31:0]; end
`ifdef ALU_VSHIFT_EN
          6'h04: begin t = ua * (64'd1 << sh); r = t[31:0]; end
          6'h06: begin t = ua / (64'd1 << sh); r = t[31:0]; end
          6'h07: begin s = sa >>> sh; r = s[31:0]; end
`endif
          default: r = 32'd0;
        endcase
      end
      6'h08: begin s = sa + si; r = s[31:0]; f[0] = (s > S32_MAX) || (s < S32_MIN); end
      6'h09, 6'h23, 6'h2B: begin s = sa + si; r = s[31:0]; end
      6'h0A: begin r = (sa < si) ? 32'd1 : 32'd0; f[1] = r[0]; end
      6'h0B: begin r = (ua < ui) ? 32'd1 : 32'd0; f[1] = r[0]; end
      6'h04, 6'h05: begin s = sa - sb; r = s[31:0]; f[2] = (a == b); end
      default: r = 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act_r, input logic [31:0] exp_r,
                       input logic [2:0] act_f, input logic [2:0] exp_f);
    n_checks++;
    if (act_r !== exp_r || act_f !== exp_f) begin
      n_fail++;
      $display("FAIL %s: result=%08h flags=%03b, expected result=%08h flags=%03b",
               name, act_r, act_f, exp_r, exp_f);
    end
  endtask

  // Drive at the falling edge, check 1 time unit after the capturing rising edge
  task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    instruction = ins;
    regA = a;
    regB = b;
    @(posedge clock);
    #1;
  endtask

  logic [31:0] exp_r;
  logic [2:0]  exp_f;
  logic [31:0] vsh_sllv, vsh_srlv, vsh_srav;
  logic [5:0]  rfn[16];
  logic [5:0]  iop[9];

  initial begin
    instruction = 32'd0;
    regA = 32'd0;
    regB = 32'd0;
    reset_n = 1'b0;

`ifdef ALU_VSHIFT_EN
    vsh_sllv = 32'h8000001C; vsh_srlv = 32'h38000001; vsh_srav = 32'hF8000001;
`else
    vsh_sllv = 32'h0; vsh_srlv = 32'h0; vsh_srav = 32'h0;
`endif

    // Directed vectors: logic, arithmetic, shifts, immediates, branches, unsupported
    add_vec(rtype(6'h24, 5'd0), 32'h000000FF, 32'h000000A0, 32'h000000A0, 3'b000);
    add_vec(rtype(6'h25, 5'd0), 32'h000000FF, 32'h000000A0, 32'h000000FF, 3'b000);
    add_vec(rtype(6'h26, 5'd0), 32'h000000FF, 32'h000000A0, 32'h0000005F, 3'b000);
    add_vec(rtype(6'h27, 5'd0), 32'h000000FF, 32'h000000A0, 32'hFFFFFF00, 3'b000);
    add_vec(rtype(6'h20, 5'd0), 32'h80000001, 32'h80000002, 32'h00000003, 3'b001);
    add_vec(rtype(6'h21, 5'd0), 32'h80000001, 32'h80000002, 32'h00000003, 3'b000);
    add_vec(rtype(6'h22, 5'd0), 32'h80000001, 32'h80000002, 32'hFFFFFFFF, 3'b000);
    add_vec(rtype(6'h2A, 5'd0), 32'h80000001, 32'h80000002, 32'h00000001, 3'b010);
    add_vec(rtype(6'h2B, 5'd0), 32'h80000001, 32'h80000002, 32'h00000001, 3'b010);
    add_vec(rtype(6'h00, 5'd1), 32'hE0000007, 32'd2, 32'hC000000E, 3'b000);
    add_vec(rtype(6'h02, 5'd1), 32'hE0000007, 32'd2, 32'h70000003, 3'b000);
    add_vec(rtype(6'h03, 5'd1), 32'hE0000007, 32'd2, 32'hF0000003, 3'b000);
    add_vec(rtype(6'h04, 5'd1), 32'hE0000007, 32'd2, vsh_sllv, 3'b000);
    add_vec(rtype(6'h06, 5'd1), 32'hE0000007, 32'd2, vsh_srlv, 3'b000);
    add_vec(rtype(6'h07, 5'd1), 32'hE0000007, 32'd2, vsh_srav, 3'b000);
    add_vec(itype(6'h08, 16'h8001), 32'h80000001, 32'd0, 32'h7FFF8002, 3'b001);
    add_vec(itype(6'h09, 16'h8001), 32'h80000001, 32'd0, 32'h7FFF8002, 3'b000);
    add_vec(itype(6'h0A, 16'h8001), 32'h80000001, 32'd0, 32'h00000001, 3'b010);
    add_vec(itype(6'h0B, 16'h8001), 32'h80000001, 32'd0, 32'h00000001, 3'b010);
    add_vec(itype(6'h23, 16'h8001), 32'd3, 32'd0, 32'hFFFF8004, 3'b000);
    add_vec(itype(6'h2B, 16'h8001), 32'h7FFFFFFF, 32'd0, 32'h7FFF8000, 3'b000);
    add_vec(itype(6'h04, 16'h0000), 32'd123, 32'd123, 32'h00000000, 3'b100);
    add_vec(itype(6'h05, 16'h0000), 32'd123, 32'd123, 32'h00000000, 3'b100);
    add_vec(itype(6'h04, 16'h0000), 32'd123, 32'd124, 32'hFFFFFFFF, 3'b000);
    add_vec(itype(6'h3F, 16'h1234), 32'd5, 32'd7, 32'h00000000, 3'b000);
    add_vec(rtype(6'h3F, 5'd3), 32'd5, 32'd7, 32'h00000000, 3'b000);
    add_vec(rtype(6'h20, 5'd0), 32'h7FFFFFFF, 32'd1, 32'h80000000, 3'b001);
    add_vec(rtype(6'h22, 5'd0), 32'h80000000, 32'd1, 32'h7FFFFFFF, 3'b001);
    add_vec(rtype(6'h23, 5'd0), 32'h80000000, 32'd1, 32'h7FFFFFFF, 3'b000);

    // Reset state, including across a clock edge with inputs driven
    instruction = rtype(6'h25, 5'd0);
    regA = 32'h12345678;
    #12;
    check("reset_hold", result, 32'd0, flags, 3'b000);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("first_capture", result, 32'h12345678, flags, 3'b000);

    // Table-driven vectors, back to back
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].ins, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d", i), result, vecs[i].res, flags, vecs[i].flg);
    end

    // Asynchronous reset between edges clears outputs at once
    apply(rtype(6'h20, 5'd0), 32'h7FFFFFFF, 32'd1);
    check("pre_reset", result, 32'h80000000, flags, 3'b001);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", result, 32'd0, flags, 3'b000);
    // Operation in flight while reset is held is discarded
    @(posedge clock);
    #1;
    check("reset_discard", result, 32'd0, flags, 3'b000);
    @(negedge clock);
    reset_n = 1'b1;
    instruction = rtype(6'h2A, 5'd0);
    regA = 32'hFFFFFFFF;
    regB = 32'd0;
    @(posedge clock);
    #1;
    check("post_reset_op", result, 32'd1, flags, 3'b010);

    // Randomized operations against the model
    rfn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    iop = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};
    for (int k = 0; k < 400; k++) begin
      logic [31:0] ins, a, b;
      int sel;
      sel = int'($urandom_range(0, 9));
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? 32'h80000000 : 32'h7FFFFFFF;
      if (sel < 5) begin
        ins = $urandom();
        ins[31:26] = 6'h00;
        ins[5:0] = rfn[$urandom_range(0, 15)];
      end else if (sel < 9) begin
        ins = $urandom();
        ins[31:26] = iop[$urandom_range(0, 8)];
      end else begin
        ins = $urandom();
      end
      model(ins, a, b, exp_r, exp_f);
      apply(ins, a, b);
      check($sformatf("rand%0d ins=%08h a=%08h b=%08h", k, ins, a, b), result, exp_r, flags, exp_f);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 clock  input  1  single clock; outputs update on its rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 instruction  input  32  MIPS-format word: opcode[31:26], shamt[10:6], funct[5:0], imm[15:0].
REQ-004 regA  input  32  first operand (rs value); shift source for all shifts.
REQ-005 regB  input  32  second operand (rt value); variable shift amount from regB[4:0].
REQ-006 result  output  32  registered operation result.
REQ-007 flags  output  3  registered flags: [2]=zero, [1]=negative, [0]=overflow.

Function
REQ-008 All inputs are sampled at each rising clock edge; result and flags are registered and valid one cycle later. There is no handshake, and a new operation is accepted every cycle.
REQ-009 For opcode 0x00, funct selects the operation:
- 0x20 add, 0x21 addu, 0x22 sub (A-B), 0x23 subu
- 0x24 and, 0x25 or, 0x26 xor, 0x27 nor
- 0x2A slt (signed), 0x2B sltu
- 0x00 sll, 0x02 srl, 0x03 sra: regA shifted by shamt
- 0x04 sllv, 0x06 srlv, 0x07 srav: regA shifted by regB[4:0]
REQ-010 I-type opcodes use the sign-extended imm[15:0]:
- 0x08 addi, 0x09 addiu: A+imm
- 0x0A slti: signed compare; 0x0B sltiu: unsigned compare against the sign-extended imm
- 0x23 lw, 0x2B sw: result is the address A+imm; overflow is never flagged
- 0x04 beq, 0x05 bne: result is A-B
REQ-011 All arithmetic is 32-bit and wraps modulo 2^32.
REQ-012 The slt-class operations return 32'd1 when the comparison is true and 32'd0 otherwise.
REQ-013 overflow (flags[0]) is set only by add, sub and addi, on signed overflow (operand signs agree and the result sign differs; for sub, against the negated B). It is 0 for all other operations, including addu, subu and addiu.
REQ-014 negative (flags[1]) is set only by slt, sltu, slti and sltiu, and equals the comparison outcome (result==1).
REQ-015 zero (flags[2]) is set only by beq and bne, when regA==regB.
REQ-016 Any unsupported opcode or funct yields result=0 and flags=0.

Reset
REQ-017 While reset_n is low, result=32'h0 and flags=3'b000, immediately and independent of clock.
REQ-018 An operation in flight when reset asserts is discarded. The first operation is captured on the first rising edge after reset_n deasserts.

Configuration
REQ-019 With macro ALU_VSHIFT_EN defined, sllv, srlv and srav are implemented per REQ-009. Without it, these funct codes are treated as unsupported (REQ-016) and the variable-shift logic is absent.

Structure
REQ-020 Shared package alu_pkg holds:
- opcode and funct localparams
- flag bit-index constants
- an operation enum type
REQ-021 One sub-module, alu_shifter, is provided: a combinational 32-bit barrel shifter with inputs data, amount[4:0] and mode (logical left, logical right, arithmetic right).
REQ-022 Decode, operation and flag generation in alu are combinational, followed by a single output register stage.

Verification
REQ-023 Logic: regA=0x000000FF, regB=0x000000A0.
- and -> 0x000000A0
- or -> 0x000000FF
- xor -> 0x0000005F
- nor -> 0xFFFFFF00
- flags 000 for all, each one cycle after the input.
REQ-024 Arithmetic: regA=0x80000001, regB=0x80000002.
- add -> 0x00000003, flags 001
- addu -> 0x00000003, flags 000
- sub -> 0xFFFFFFFF, flags 000
- slt -> 1, flags 010
- sltu -> 1, flags 010
REQ-025 Shifts: regA=0xE0000007, regB=2, shamt=1.
- sll -> 0xC000000E
- srl -> 0x70000003
- sra -> 0xF0000003
- sllv -> 0x8000001C
- srlv -> 0x38000001
- srav -> 0xF8000001
- Rebuilt without ALU_VSHIFT_EN, the three variable shifts return 0.
REQ-026 Immediate: regA=0x80000001, imm=0x8001.
- addi -> 0x7FFF8002, flags 001
- addiu -> 0x7FFF8002, flags 000
- slti -> 1, flags 010
- sltiu -> 1, flags 010
- lw with regA=3 -> 0xFFFF8004, flags 000
REQ-027 Branch and reset:
- regA=regB=123: beq and bne each -> result 0, flags 100.
- regA=123, regB=124: beq -> 0xFFFFFFFF, flags 000.
- reset_n pulsed low between clock edges -> outputs go to 0 at once.
- Opcode 0x3F -> result 0, flags 000.
